free_list: RTL and testbench

- Circular queue of free physical register indices for the out-of-order core.
- The rename/decode stage dequeues one physical destination per cycle and drives it into the rename table's `pd` input.
- The commit stage enqueues the displaced old physical register of each retiring instruction.
- A retirement head pointer restores all speculatively allocated registers on `flush`, so this block is the supply end of the rename table's `pd`/`rat_we` interface.

---
 rtl/free_list_if.sv | 33 +++
 rtl/free_list.sv | 76 +++++++
 tb/tb_free_list.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - rename/commit/flush port bundle of the physical register free list
interface free_list_if #(
   parameter int PR_WIDTH = 6,
   parameter int PTR_W    = 6
);
   logic                alloc_req;
   logic [PR_WIDTH-1:0] alloc_pd;
   logic                alloc_valid;
   logic                free_we;
   logic [PR_WIDTH-1:0] free_pd;
   logic                flush;
   logic [PTR_W-1:0]    free_count;

   modport master (
      output alloc_req,
      output free_we,
      output free_pd,
      output flush,
      input  alloc_pd,
      input  alloc_valid,
      input  free_count
   );

   modport slave (
      input  alloc_req,
      input  free_we,
      input  free_pd,
      input  flush,
      output alloc_pd,
      output alloc_valid,
      output free_count
   );
endinterface

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free list of physical register indices with flush recovery
module free_list #(
   parameter int PR_WIDTH  = 6,
   parameter int NUM_PREGS = 64,
   parameter int NUM_AREGS = 32,
   parameter int DEPTH     = NUM_PREGS - NUM_AREGS,
   parameter int PTR_W     = $clog2(DEPTH) + 1
) (
   input  logic       clk,
   input  logic       rst,
   free_list_if.slave fl
);
   localparam int IDX_W = PTR_W - 1;

   logic [PR_WIDTH-1:0] queue_q [DEPTH];
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [PTR_W-1:0]    rhead_q, rhead_d;
   logic [PTR_W-1:0]    count;
   logic                alloc_valid;
   logic                do_alloc;
   logic                do_free;

   assign count          = tail_q - head_q;
   assign alloc_valid    = (count != '0);
   assign fl.alloc_valid = alloc_valid;
   assign fl.free_count  = count;
   assign fl.alloc_pd    = queue_q[head_q[IDX_W-1:0]];

   // A flush rewinds head to the retirement point, including this cycle's commit.
   always_comb begin
      do_alloc = fl.alloc_req && alloc_valid && !fl.flush;
      do_free  = fl.free_we && (count != PTR_W'(DEPTH));
      head_d   = head_q;
      tail_d   = tail_q;
      rhead_d  = rhead_q;
      if (do_free) begin
         tail_d  = tail_q + PTR_W'(1);
         rhead_d = rhead_q + PTR_W'(1);
      end
      if (fl.flush) begin
         head_d = rhead_d;
      end else if (do_alloc) begin
         head_d = head_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         rhead_q <= '0;
         tail_q  <= PTR_W'(DEPTH);
         for (int i = 0; i < DEPTH; i++) begin
            queue_q[i] <= PR_WIDTH'(NUM_AREGS + i);
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         rhead_q <= rhead_d;
         if (do_free) begin
            queue_q[tail_q[IDX_W-1:0]] <= fl.free_pd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(fl.alloc_req && !alloc_valid && !fl.flush))
            else $warning("alloc_req while free list empty, request ignored");
         assert (!(fl.free_we && (count == PTR_W'(DEPTH))))
            else $warning("free_we while free list full, enqueue ignored");
         assert ((tail_q - rhead_q) == PTR_W'(DEPTH))
            else $error("tail and rhead no longer DEPTH apart");
      end
   end
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - randomized scoreboard bench for free_list against a queue model
module tb_free_list;
   localparam int PRW   = 6;
   localparam int DEPTH = 32;
   localparam int PTRW  = 6;

   typedef struct {
      bit valid;
      int pd;
      int count;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   free_list_if #(.PR_WIDTH(PRW), .PTR_W(PTRW)) fl_if ();

   free_list #(
      .PR_WIDTH (PRW),
      .NUM_PREGS(64),
      .NUM_AREGS(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fl (fl_if)
   );

   exp_t exp_q[$];
   int   free_q[$];   // free registers, next allocation first
   int   spec_q[$];   // allocated but not yet committed, oldest first
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   task automatic chk(input string name, input int at, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, at, act, req);
      end
   endtask

   task automatic model_reset();
      free_q.delete();
      spec_q.delete();
      for (int i = 0; i < DEPTH; i++) free_q.push_back(32 + i);
   endtask

   // Drive one cycle of inputs and record what the list must look like after the edge.
   task automatic step(input bit r, input bit req, input bit we, input int pd, input bit fls);
      exp_t e;
      bit   free_ok;
      int   got;
      @(negedge clk);
      rst              = r;
      fl_if.alloc_req  = req;
      fl_if.free_we    = we;
      fl_if.free_pd    = PRW'(pd);
      fl_if.flush      = fls;
      if (r) begin
         model_reset();
      end else begin
         free_ok = we && (spec_q.size() != 0);
         if (req && !fls && free_q.size() != 0) begin
            got = free_q.pop_front();
            spec_q.push_back(got);
         end
         if (free_ok) begin
            void'(spec_q.pop_front());
            free_q.push_back(pd);
         end
         if (fls) begin
            free_q = {spec_q, free_q};
            spec_q.delete();
         end
      end
      e.valid = (free_q.size() != 0);
      e.pd    = e.valid ? free_q[0] : 0;
      e.count = free_q.size();
      e.cyc   = cyc;
      exp_q.push_back(e);
      cyc++;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("alloc_valid", e.cyc, int'(fl_if.alloc_valid), int'(e.valid));
         chk("free_count", e.cyc, int'(fl_if.free_count), e.count);
         if (e.valid) chk("alloc_pd", e.cyc, int'(fl_if.alloc_pd), e.pd);
      end
   end

   initial begin
      int p;
      bit r, req, we, fls;
      rst             = 1'b1;
      fl_if.alloc_req = 1'b0;
      fl_if.free_we   = 1'b0;
      fl_if.free_pd   = '0;
      fl_if.flush     = 1'b0;

      // reset state, then three back-to-back allocations
      step(1, 0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0);

      // drain to empty, refused extra request, then a free refills the head
      repeat (29) step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 5, 0);

      // four allocations, two commits, flush recovers the uncommitted two
      step(1, 0, 0, 0, 0);
      repeat (4) step(0, 1, 0, 0, 0);
      step(0, 0, 1, 7, 0);
      step(0, 0, 1, 9, 0);
      step(0, 0, 0, 0, 1);
      repeat (32) step(0, 1, 0, 0, 0);

      // flush together with a commit and an ignored allocation
      step(1, 0, 0, 0, 0);
      repeat (3) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 12, 1);

      // wrap-around with alloc/free pairs returning the same register
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         p = free_q[0];
         step(0, 1, 0, 0, 0);
         step(0, 0, 1, p, 0);
      end

      // reset wins over everything else in the same cycle
      repeat (5) step(0, 1, 0, 0, 0);
      step(1, 1, 1, 3, 1);

      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom % 300) == 0;
         fls = ($urandom % 30) == 0;
         req = (free_q.size() != 0) && (($urandom % 4) != 0);
         we  = (spec_q.size() != 0) && (($urandom % 3) == 0);
         step(r, req, we, int'($urandom_range(0, 63)), fls);
      end

      step(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", cyc, exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
